// File: rtl/id_stage_hazard_if.sv
// rtl/id_stage_hazard_if.sv - IF/ID, ID/EX, write-back and flush signals of the decode stage
interface id_stage_hazard_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_ir;
  logic [XLEN-1:0] in_pc;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [AW-1:0]   out_rs1_addr;
  logic [AW-1:0]   out_rs2_addr;
  logic [XLEN-1:0] out_rs1_data;
  logic [XLEN-1:0] out_rs2_data;
  logic [AW-1:0]   out_rd;
  logic            out_is_load;

  logic            wb_en;
  logic [AW-1:0]   wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            flush;

  modport master (
    output in_valid, in_ir, in_pc, out_ready, wb_en, wb_rd, wb_data, flush,
    input  in_ready, out_valid, out_pc, out_rs1_addr, out_rs2_addr,
           out_rs1_data, out_rs2_data, out_rd, out_is_load
  );

  modport slave (
    input  in_valid, in_ir, in_pc, out_ready, wb_en, wb_rd, wb_data, flush,
    output in_ready, out_valid, out_pc, out_rs1_addr, out_rs2_addr,
           out_rs1_data, out_rs2_data, out_rd, out_is_load
  );
endinterface

// File: rtl/id_stage_hazard.sv
// rtl/id_stage_hazard.sv - decode stage: register file with bypass, load-use bubble, ID/EX register
module id_stage_hazard #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  id_stage_hazard_if.slave bus,
  output logic [CNT_W-1:0] hazard_cnt
);
  localparam int AW = $clog2(NREGS);
  localparam logic [6:0] OP_LOAD = 7'b0000011;

  logic [XLEN-1:0] regs [NREGS];

  logic [AW-1:0]   rs1, rs2, rd;
  logic            is_load;
  logic [XLEN-1:0] rs1_data, rs2_data;
  logic            advance, hazard;

  logic            v_q;
  logic [XLEN-1:0] pc_q, rs1_data_q, rs2_data_q;
  logic [AW-1:0]   rs1_q, rs2_q, rd_q;
  logic            load_q;
  logic [CNT_W-1:0] cnt_q;

  logic unused_ir;
  assign unused_ir = ^{bus.in_ir[31:25], bus.in_ir[14:12]};

  assign rs1     = AW'(bus.in_ir[19:15]);
  assign rs2     = AW'(bus.in_ir[24:20]);
  assign rd      = AW'(bus.in_ir[11:7]);
  assign is_load = (bus.in_ir[6:0] == OP_LOAD);

  // x0 reads zero; a write-back to the same index in this cycle is forwarded
  always_comb begin
    rs1_data = regs[rs1];
    rs2_data = regs[rs2];
    if (rs1 == '0)
      rs1_data = '0;
    else if (bus.wb_en && bus.wb_rd == rs1)
      rs1_data = bus.wb_data;
    if (rs2 == '0)
      rs2_data = '0;
    else if (bus.wb_en && bus.wb_rd == rs2)
      rs2_data = bus.wb_data;
  end

  assign advance = !v_q || bus.out_ready;
  assign hazard  = bus.in_valid && v_q && load_q && (rd_q != '0) &&
                   ((rd_q == rs1) || (rd_q == rs2));
  assign bus.in_ready = bus.flush || (advance && !hazard);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++)
        regs[i] <= '0;
    end else if (bus.wb_en && bus.wb_rd != '0) begin
      regs[bus.wb_rd] <= bus.wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v_q        <= 1'b0;
      pc_q       <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      rd_q       <= '0;
      load_q     <= 1'b0;
      cnt_q      <= '0;
    end else if (bus.flush) begin
      v_q <= 1'b0;
    end else if (advance) begin
      if (hazard) begin
        v_q <= 1'b0;
        if (cnt_q != {CNT_W{1'b1}})
          cnt_q <= cnt_q + CNT_W'(1);
      end else if (bus.in_valid) begin
        v_q        <= 1'b1;
        pc_q       <= bus.in_pc;
        rs1_q      <= rs1;
        rs2_q      <= rs2;
        rs1_data_q <= rs1_data;
        rs2_data_q <= rs2_data;
        rd_q       <= rd;
        load_q     <= is_load;
      end else begin
        v_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid    = v_q;
  assign bus.out_pc       = pc_q;
  assign bus.out_rs1_addr = rs1_q;
  assign bus.out_rs2_addr = rs2_q;
  assign bus.out_rs1_data = rs1_data_q;
  assign bus.out_rs2_data = rs2_data_q;
  assign bus.out_rd       = rd_q;
  assign bus.out_is_load  = load_q;
  assign hazard_cnt       = cnt_q;
endmodule

// File: tb/tb_id_stage_hazard.sv
// tb/tb_id_stage_hazard.sv - directed and randomized checks of id_stage_hazard against a behavioural model
module tb_id_stage_hazard;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;
  localparam int CNT_W = 2;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk, rst;
  logic [CNT_W-1:0] hazard_cnt;
  id_stage_hazard_if #(.XLEN(XLEN), .AW(AW)) bus ();

  id_stage_hazard #(.XLEN(XLEN), .NREGS(NREGS), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .bus(bus), .hazard_cnt(hazard_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] enc(input int rd, input int rs1, input int rs2, input logic [6:0] op);
    logic [4:0] a, b, d;
    a = 5'(rs1); b = 5'(rs2); d = 5'(rd);
    return {7'b0, b, a, 3'b0, d, op};
  endfunction

  // Behavioural model: architectural register contents plus the ID/EX slot
  logic [XLEN-1:0] mregs [NREGS];
  bit              m_valid, m_load;
  logic [XLEN-1:0] m_pc, m_d1, m_d2;
  int              m_a1, m_a2, m_rd, m_cnt;

  function automatic logic [XLEN-1:0] m_read(input int idx);
    if (idx == 0) return '0;
    if (bus.wb_en && int'(bus.wb_rd) == idx) return bus.wb_data;
    return mregs[idx];
  endfunction

  function automatic bit m_hazard();
    int s1, s2;
    s1 = int'(bus.in_ir[19:15]);
    s2 = int'(bus.in_ir[24:20]);
    return bus.in_valid && m_valid && m_load && m_rd != 0 && (m_rd == s1 || m_rd == s2);
  endfunction

  function automatic bit m_ready();
    return bus.flush || ((!m_valid || bus.out_ready) && !m_hazard());
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_valid = 0; m_load = 0; m_pc = '0; m_d1 = '0; m_d2 = '0;
      m_a1 = 0; m_a2 = 0; m_rd = 0; m_cnt = 0;
      for (int i = 0; i < NREGS; i++) mregs[i] = '0;
    end else begin
      if (bus.flush)
        m_valid = 0;
      else if (m_valid && !bus.out_ready)
        m_valid = m_valid;
      else if (m_hazard()) begin
        m_valid = 0;
        m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
      end else if (bus.in_valid) begin
        m_valid = 1;
        m_pc = bus.in_pc;
        m_a1 = int'(bus.in_ir[19:15]);
        m_a2 = int'(bus.in_ir[24:20]);
        m_rd = int'(bus.in_ir[11:7]);
        m_d1 = m_read(m_a1);
        m_d2 = m_read(m_a2);
        m_load = (bus.in_ir[6:0] == 7'h03);
      end else
        m_valid = 0;
      if (bus.wb_en && bus.wb_rd != 0) mregs[bus.wb_rd] = bus.wb_data;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("out_valid", 64'(bus.out_valid), 64'(m_valid));
      chk("in_ready", 64'(bus.in_ready), 64'(m_ready()));
      chk("hazard_cnt", 64'(hazard_cnt), 64'(m_cnt));
      if (m_valid) begin
        chk("out_pc", 64'(bus.out_pc), 64'(m_pc));
        chk("out_rs1_addr", 64'(bus.out_rs1_addr), 64'(m_a1));
        chk("out_rs2_addr", 64'(bus.out_rs2_addr), 64'(m_a2));
        chk("out_rs1_data", 64'(bus.out_rs1_data), 64'(m_d1));
        chk("out_rs2_data", 64'(bus.out_rs2_data), 64'(m_d2));
        chk("out_rd", 64'(bus.out_rd), 64'(m_rd));
        chk("out_is_load", 64'(bus.out_is_load), 64'(m_load));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input logic [31:0] ir, input logic [31:0] pc);
    bus.in_valid = 1'b1;
    bus.in_ir = ir;
    bus.in_pc = pc;
  endtask

  initial begin
    rst = 1'b0;
    bus.in_valid = 0; bus.in_ir = '0; bus.in_pc = '0; bus.out_ready = 1;
    bus.wb_en = 0; bus.wb_rd = '0; bus.wb_data = '0; bus.flush = 0;
    tick(); tick();
    chk("reset out_valid", 64'(bus.out_valid), 64'd0);
    chk("reset hazard_cnt", 64'(hazard_cnt), 64'd0);
    rst = 1'b1;
    chk_en = 1'b1;

    // operands from the register file
    bus.wb_en = 1; bus.wb_rd = 5; bus.wb_data = 32'hDEADBEEF; tick();
    bus.wb_rd = 6; bus.wb_data = 32'h1234; tick();
    bus.wb_en = 0;
    issue(32'h006283B3, 32'h100); tick();
    bus.in_valid = 0;
    chk("add out_valid", 64'(bus.out_valid), 64'd1);
    chk("add rs1_data", 64'(bus.out_rs1_data), 64'hDEADBEEF);
    chk("add rs2_data", 64'(bus.out_rs2_data), 64'h1234);
    chk("add rd", 64'(bus.out_rd), 64'd7);

    // same-cycle write-back bypass, and x0 stays zero
    issue(enc(1, 2, 0, 7'h33), 32'h104);
    bus.wb_en = 1; bus.wb_rd = 2; bus.wb_data = 32'h55; tick();
    chk("bypass rs1_data", 64'(bus.out_rs1_data), 64'h55);
    chk("bypass rs2_data", 64'(bus.out_rs2_data), 64'h0);
    bus.wb_rd = 0; bus.wb_data = 32'hFF; issue(enc(1, 0, 0, 7'h33), 32'h108); tick();
    bus.wb_en = 0; tick();
    chk("x0 rs1_data", 64'(bus.out_rs1_data), 64'h0);

    // load-use pair costs one bubble
    issue(enc(3, 4, 0, 7'h03), 32'h10C); tick();
    issue(enc(5, 3, 1, 7'h33), 32'h110); #1;
    chk("load-use in_ready", 64'(bus.in_ready), 64'd0);
    tick();
    chk("bubble out_valid", 64'(bus.out_valid), 64'd0);
    chk("bubble hazard_cnt", 64'(hazard_cnt), 64'd1);
    tick();
    chk("after bubble out_rd", 64'(bus.out_rd), 64'd5);
    chk("after bubble out_valid", 64'(bus.out_valid), 64'd1);
    issue(enc(0, 4, 0, 7'h03), 32'h114); tick();
    issue(enc(5, 0, 1, 7'h33), 32'h118); #1;
    chk("x0 load in_ready", 64'(bus.in_ready), 64'd1);
    tick();
    chk("x0 load no bubble", 64'(bus.out_valid), 64'd1);
    chk("x0 load hazard_cnt", 64'(hazard_cnt), 64'd1);

    // EX stall over a pending hazard
    issue(enc(3, 4, 0, 7'h03), 32'h11C); tick();
    bus.out_ready = 0;
    issue(enc(5, 3, 1, 7'h33), 32'h120);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall in_ready", 64'(bus.in_ready), 64'd0);
      tick();
      chk("stall out_pc", 64'(bus.out_pc), 64'h11C);
      chk("stall hazard_cnt", 64'(hazard_cnt), 64'd1);
    end
    bus.out_ready = 1;
    issue(enc(6, 1, 2, 7'h33), 32'h124); tick();
    chk("release out_rd", 64'(bus.out_rd), 64'd6);

    // flush beats a pending hazard
    issue(enc(3, 4, 0, 7'h03), 32'h128); tick();
    issue(enc(5, 3, 1, 7'h33), 32'h12C); bus.flush = 1; #1;
    chk("flush in_ready", 64'(bus.in_ready), 64'd1);
    tick();
    bus.flush = 0; bus.in_valid = 0;
    chk("flush out_valid", 64'(bus.out_valid), 64'd0);
    chk("flush hazard_cnt", 64'(hazard_cnt), 64'd1);
    tick();

    // counter saturation after a fresh reset
    rst = 0; #1; rst = 1;
    for (int i = 0; i < 5; i++) begin
      issue(enc(3, 4, 0, 7'h03), 32'h200); tick();
      issue(enc(5, 3, 1, 7'h33), 32'h204); tick(); tick();
    end
    chk("saturated hazard_cnt", 64'(hazard_cnt), 64'd3);

    // asynchronous reset in the middle of a bubble
    issue(enc(3, 4, 0, 7'h03), 32'h300); tick();
    issue(enc(5, 3, 1, 7'h33), 32'h304); tick();
    chk("pre-reset out_pc", 64'(bus.out_pc), 64'h300);
    rst = 0; #1;
    chk("async out_pc", 64'(bus.out_pc), 64'h0);
    chk("async out_rd", 64'(bus.out_rd), 64'h0);
    chk("async out_is_load", 64'(bus.out_is_load), 64'h0);
    chk("async hazard_cnt", 64'(hazard_cnt), 64'h0);
    rst = 1;
    issue(enc(7, 1, 2, 7'h33), 32'h308); #1;
    chk("post-reset in_ready", 64'(bus.in_ready), 64'd1);
    tick();
    chk("post-reset out_valid", 64'(bus.out_valid), 64'd1);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_ir     = enc($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                          ($urandom_range(0, 1) != 0) ? 7'h03 : 7'h33);
      bus.in_pc     = $urandom;
      bus.out_ready = ($urandom_range(0, 9) < 7);
      bus.flush     = ($urandom_range(0, 19) == 0);
      bus.wb_en     = ($urandom_range(0, 1) != 0);
      bus.wb_rd     = 5'($urandom_range(0, 7));
      bus.wb_data   = $urandom;
      tick();
    end
    bus.in_valid = 0; bus.flush = 0; bus.wb_en = 0;
    tick(); tick();
    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/id_stage_hazard.md
Name: id_stage_hazard

Overview:
Parametrised next-generation instruction decode stage. It owns the integer register file (one write-back port and a write-through bypass), detects load-use hazards, and inserts one bubble per hazard. Results go into a registered ID/EX stage using valid/ready handshakes toward IF and EX. It sits between the fetch stage and the execute stage, and supports pipeline flush from branch resolution.

Parameters:
XLEN, 32, data and PC width
NREGS, 32, number of architectural registers; AW = $clog2(NREGS)
CNT_W, 16, width of the saturating hazard-bubble counter

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous reset, active-low (asserted when 0)
in_valid  in  1  IF/ID holds an instruction
in_ready  out  1  stage accepts the IF/ID instruction this cycle
in_ir  in  32  instruction word
in_pc  in  XLEN  instruction PC
out_valid  out  1  ID/EX register holds a valid instruction
out_ready  in  1  EX accepts the ID/EX contents
out_pc  out  XLEN  registered PC
out_rs1_addr  out  AW  registered rs1 index, used by EX forwarding
out_rs2_addr  out  AW  registered rs2 index
out_rs1_data  out  XLEN  registered rs1 operand
out_rs2_data  out  XLEN  registered rs2 operand
out_rd  out  AW  registered destination index
out_is_load  out  1  registered: opcode == 7'b0000011
wb_en  in  1  write-back enable
wb_rd  in  AW  write-back register index
wb_data  in  XLEN  write-back data
flush  in  1  discard the IF/ID instruction and the ID/EX contents
hazard_cnt  out  CNT_W  count of inserted load-use bubbles, saturating

Behaviour:
- Field decode: rs1 = in_ir[19:15], rs2 = in_ir[24:20], rd = in_ir[11:7], opcode = in_ir[6:0]. The low AW bits of each index are used.
- Reset (rst = 0, asynchronous): out_valid = 0. out_pc, out_rs1_addr, out_rs2_addr, out_rs1_data, out_rs2_data, out_rd and out_is_load = 0. hazard_cnt = 0. All registers = 0.
- Register file:
  - 2 combinational read ports and 1 synchronous write port.
  - Writes occur when wb_en = 1 and wb_rd != 0.
  - Register x0 always reads 0.
  - Bypass: if wb_en = 1, wb_rd != 0 and wb_rd equals a read index, that port returns wb_data in the same cycle.
- advance = !out_valid || out_ready.
- hazard = in_valid && out_valid && out_is_load && out_rd != 0 && (out_rd == rs1 || out_rd == rs2). The check is conservative: both fields are compared regardless of format.
- in_ready = flush || (advance && !hazard).
- Priority order each cycle:
  - 1) flush = 1: out_valid <= 0. Any offered instruction is consumed and dropped. hazard_cnt is unchanged. flush wins over hazard and over stall.
  - 2) !advance (EX stalled): all ID/EX outputs hold. in_ready = 0. hazard_cnt is unchanged, even if a hazard exists.
  - 3) advance && hazard: out_valid <= 0 (bubble). IF/ID is not consumed. hazard_cnt increments.
  - 4) advance && in_valid: capture pc, rs1/rs2 indices, rs1/rs2 data, rd and is_load; out_valid <= 1.
  - 5) advance && !in_valid: out_valid <= 0. Data outputs may hold stale values.
- Latency: 1 cycle from acceptance to out_valid. A load-use pair costs exactly 1 bubble: the hazard clears the cycle after the bubble because out_valid = 0.
- Held operands are not refreshed by later write-backs; EX forwarding covers that case.
- hazard_cnt saturates at 2^CNT_W - 1 and does not wrap.
- Reset asserted mid-stall or mid-bubble returns the stage to the reset state immediately. The first instruction after release is accepted normally.

Test Plan:
- Reset, then write x5 = 0xDEAD_BEEF and x6 = 0x1234. Issue add x7,x5,x6 (0x006283B3) with out_ready = 1 -> next cycle: out_valid = 1, out_rs1_data = 0xDEADBEEF, out_rs2_data = 0x1234, out_rd = 7.
- Same cycle as the issue of add x1,x2,x0: wb_en = 1, wb_rd = 2, wb_data = 0x55 -> out_rs1_data = 0x55 (bypass), out_rs2_data = 0. A write to x0 with 0xFF reads back 0.
- Issue lw x3,0(x4), then add x5,x3,x1 back-to-back with out_ready = 1 -> cycle 2: in_ready = 0, out_valid = 0 (bubble). Cycle 3: add issued. hazard_cnt = 1. Using rd = x0 for the load -> no bubble.
- Hold out_ready = 0 for 3 cycles with a valid entry -> all outputs stable, in_ready = 0, no hazard_cnt change. Release -> the next instruction is captured within 1 cycle.
- Assert flush together with in_valid and a pending hazard -> in_ready = 1, out_valid = 0 next cycle, hazard_cnt unchanged.
- With CNT_W = 2, force 5 load-use bubbles -> hazard_cnt = 3. Pull rst low mid-bubble -> all outputs 0 asynchronously, before the next clock edge.
